alp_slice: RTL

- Data-path slice (ALP) directly downstream of the ALK control chip.
- Consumes the ALK opcode bits, the carry out and the open-drain shift pad levels. Produces the ALU result, the Q register contents, carry out, and the ALU/Q shift-out pad levels that the ALK routes.
- Slices are cascaded LSB-to-MSB to form the 32-bit data path.

---
 rtl/alp_pkg.sv | 31 +++
 rtl/alp_alu.sv | 72 +++++++
 rtl/alp_slice.sv | 111 +++++++++++
 3 files changed

// File: rtl/alp_pkg.sv
// Shared code definitions for the ALP data-path slice: ALU function, ALU shift
// and Q-register control encodings as carried on the ALK opcode bits.
package alp_pkg;

  typedef enum logic [2:0] {
    ALP_ADD   = 3'd0,
    ALP_SUB   = 3'd1,
    ALP_AND   = 3'd2,
    ALP_OR    = 3'd3,
    ALP_XOR   = 3'd4,
    ALP_PASSA = 3'd5,
    ALP_PASSB = 3'd6,
    ALP_ZERO  = 3'd7
  } alp_fn_e;

  // Code 3 behaves exactly like NONE; it is named so every opcode value maps to a member.
  typedef enum logic [1:0] {
    ALPSHF_NONE = 2'd0,
    ALPSHF_SHL  = 2'd1,
    ALPSHF_SHR  = 2'd2,
    ALPSHF_NOP3 = 2'd3
  } alp_shf_e;

  typedef enum logic [1:0] {
    ALPQ_HOLD = 2'd0,
    ALPQ_LOAD = 2'd1,
    ALPQ_SHL  = 2'd2,
    ALPQ_SHR  = 2'd3
  } alp_q_e;

endpackage

// File: rtl/alp_alu.sv
// Combinational adder/logic unit of the ALP slice, producing the raw result and
// logic carry out. Decimal ADD correction is built when ALP_SLICE_BCD_EN is defined.
module alp_alu
  import alp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alp_fn_e          fn,
  input  logic             cin,
  input  logic             bcd,
  output logic [WIDTH-1:0] r,
  output logic             cout
);

  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum;

`ifdef ALP_SLICE_BCD_EN
  // Nibble-serial decimal add: any digit sum above 9 is corrected by +6 and carries.
  function automatic logic [WIDTH:0] bcd_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic             c);
    logic [4:0]       s;
    logic             cy;
    logic [WIDTH-1:0] res;
    cy  = c;
    res = '0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      s = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'b0000, cy};
      if (s > 5'd9) begin
        s  = s + 5'd6;
        cy = 1'b1;
      end else begin
        cy = 1'b0;
      end
      res[4*i +: 4] = s[3:0];
    end
    return {cy, res};
  endfunction
`else
  logic unused_bcd;
  assign unused_bcd = bcd;
`endif

  assign b_sel = (fn == ALP_SUB) ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_sel} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    r    = '0;
    cout = 1'b0;
    case (fn)
      ALP_ADD, ALP_SUB: begin
        r    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
      end
      ALP_AND:   r = a & b;
      ALP_OR:    r = a | b;
      ALP_XOR:   r = a ^ b;
      ALP_PASSA: r = a;
      ALP_PASSB: r = b;
      default:   r = '0;
    endcase
`ifdef ALP_SLICE_BCD_EN
    if (fn == ALP_ADD && bcd) begin
      {cout, r} = bcd_add(a, b, cin);
    end
`endif
  end

endmodule

// File: rtl/alp_slice.sv
// ALP data-path slice: ALU, ALU/Q shifters, Q register and result flags, cascadable
// LSB-to-MSB. Optional decimal ADD is enabled by defining ALP_SLICE_BCD_EN.
module alp_slice
  import alp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             qdclk_l,
  input  logic             reset_h,
  input  logic             ena_h,
  input  logic [WIDTH-1:0] a_h,
  input  logic [WIDTH-1:0] b_h,
  input  logic [6:0]       alkop_h,
  input  logic             cin_l,
  output logic             cout_l,
  input  logic             a_sil_l,
  input  logic             a_sih_l,
  output logic             a_sol_l,
  output logic             a_soh_l,
  input  logic             q_sil_l,
  input  logic             q_sih_l,
  output logic             q_sol_l,
  output logic             q_soh_l,
  input  logic             bcd_l,
  output logic [WIDTH-1:0] f_h,
  output logic [WIDTH-1:0] q_h,
  output logic             zero_h,
  output logic             neg_h
);

  alp_fn_e          fn;
  alp_shf_e         shf;
  alp_q_e           qop;
  logic [WIDTH-1:0] r_p0, f_nxt_p0, q_nxt_p0;
  logic             cout_p0;
  logic [WIDTH-1:0] f_p1, q_p1;
  logic             zero_p1, neg_p1;

  assign fn  = alp_fn_e'(alkop_h[6:4]);
  assign shf = alp_shf_e'(alkop_h[3:2]);
  assign qop = alp_q_e'(alkop_h[1:0]);

  alp_alu #(.WIDTH(WIDTH)) u_alu (
    .a    (a_h),
    .b    (b_h),
    .fn   (fn),
    .cin  (~cin_l),
    .bcd  (~bcd_l),
    .r    (r_p0),
    .cout (cout_p0)
  );

  assign cout_l = ~cout_p0;

  // Shift-out pads look only at R, never at shift-in pads, so cascades stay loop-free.
  always_comb begin
    f_nxt_p0 = r_p0;
    a_sol_l  = 1'b1;
    a_soh_l  = 1'b1;
    case (shf)
      ALPSHF_SHL: begin
        f_nxt_p0 = {r_p0[WIDTH-2:0], ~a_sil_l};
        a_soh_l  = ~r_p0[WIDTH-1];
      end
      ALPSHF_SHR: begin
        f_nxt_p0 = {~a_sih_l, r_p0[WIDTH-1:1]};
        a_sol_l  = ~r_p0[0];
      end
      default: f_nxt_p0 = r_p0;
    endcase
  end

  always_comb begin
    q_nxt_p0 = q_p1;
    q_sol_l  = 1'b1;
    q_soh_l  = 1'b1;
    case (qop)
      ALPQ_LOAD: q_nxt_p0 = f_nxt_p0;
      ALPQ_SHL: begin
        q_nxt_p0 = {q_p1[WIDTH-2:0], ~q_sil_l};
        q_soh_l  = ~q_p1[WIDTH-1];
      end
      ALPQ_SHR: begin
        q_nxt_p0 = {~q_sih_l, q_p1[WIDTH-1:1]};
        q_sol_l  = ~q_p1[0];
      end
      default: q_nxt_p0 = q_p1;
    endcase
  end

  // ---- p0 -> p1 register boundary ----
  always_ff @(posedge qdclk_l) begin
    if (reset_h) begin
      f_p1    <= '0;
      q_p1    <= '0;
      zero_p1 <= 1'b0;
      neg_p1  <= 1'b0;
    end else if (ena_h) begin
      f_p1    <= f_nxt_p0;
      q_p1    <= q_nxt_p0;
      zero_p1 <= (f_nxt_p0 == '0);
      neg_p1  <= f_nxt_p0[WIDTH-1];
    end
  end

  assign f_h    = f_p1;
  assign q_h    = q_p1;
  assign zero_h = zero_p1;
  assign neg_h  = neg_p1;

endmodule
